// File: rtl/kt_pkg.sv
// Shared types, knight direction tables and cell indexing for the knight's-tour solver.
package kt_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, OUT} state_e;

  // Direction d: (dx, dy) as 4-bit signed steps.
  localparam logic signed [3:0] DX [8] = '{-4'sd1, 4'sd1, 4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2};
  localparam logic signed [3:0] DY [8] = '{4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1};

  function automatic logic [5:0] idx(input logic [2:0] x, input logic [2:0] y, input int unsigned n);
    return 6'((32'(x) * n) + 32'(y));
  endfunction

endpackage

// File: rtl/kt_move_gen.sv
// Combinational knight-move generator: candidate cell and on-board flag for one direction.
module kt_move_gen
  import kt_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [2:0] x_i,
  input  logic [2:0] y_i,
  input  logic [2:0] dir_i,
  output logic [2:0] cand_x_o,
  output logic [2:0] cand_y_o,
  output logic       in_bound_o
);

  logic signed [3:0] sx;
  logic signed [3:0] sy;

  // Any wrap past +7 lands negative, so the sign bit alone rejects it.
  always_comb begin
    sx         = $signed({1'b0, x_i}) + DX[dir_i];
    sy         = $signed({1'b0, y_i}) + DY[dir_i];
    cand_x_o   = sx[2:0];
    cand_y_o   = sy[2:0];
    in_bound_o = !sx[3] && !sy[3] && ({2'b00, sx[2:0]} < 5'(N)) && ({2'b00, sy[2:0]} < 5'(N));
  end

endmodule

// File: rtl/kt_tour_solver.sv
// Knight's-tour solver: loads a path prefix, completes it by DFS with backtracking, streams the tour.
module kt_tour_solver
  import kt_pkg::*;
#(
  parameter  int unsigned N     = 5,
  localparam int unsigned CELLS = N * N,
  localparam int unsigned MW    = $clog2(CELLS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [2:0]    in_x,
  input  logic [2:0]    in_y,
  input  logic [MW-1:0] move_num,
  input  logic [2:0]    priority_num,
  output logic          out_valid,
  output logic [2:0]    out_x,
  output logic [2:0]    out_y,
  output logic [MW-1:0] move_out,
  output logic          out_fail
);

  localparam int unsigned   IW      = $clog2(CELLS);
  localparam logic [MW-1:0] FULL    = MW'(CELLS);
  localparam logic [MW-1:0] LAST_M1 = MW'(CELLS - 2);

  state_e        state_q;
  logic [2:0]    px_q    [CELLS];
  logic [2:0]    py_q    [CELLS];
  logic [3:0]    tries_q [CELLS];
  logic [CELLS-1:0] vis_q;
  logic [MW-1:0] k_q, kmin_q, len_q, cnt_q;
  logic [2:0]    prio_q;
  logic          fail_q;
  logic          out_valid_q, out_fail_q;
  logic [2:0]    out_x_q, out_y_q;
  logic [MW-1:0] move_q;

  logic [IW-1:0] k_idx, k_nxt_idx, cur_cell, cand_cell, ld_cell;
  logic [2:0]    dir_c, cand_x, cand_y;
  logic          in_bound, legal_c, tries_full_c;
  logic [MW-1:0] kmin_c;

  kt_move_gen #(.N(N)) u_move_gen (
    .x_i       (px_q[k_idx]),
    .y_i       (py_q[k_idx]),
    .dir_i     (dir_c),
    .cand_x_o  (cand_x),
    .cand_y_o  (cand_y),
    .in_bound_o(in_bound)
  );

  // Candidate evaluation at the current depth.
  always_comb begin
    k_idx        = IW'(k_q);
    k_nxt_idx    = IW'(k_q + MW'(1));
    dir_c        = prio_q + tries_q[k_idx][2:0];
    cur_cell     = IW'(idx(px_q[k_idx], py_q[k_idx], N));
    cand_cell    = IW'(idx(cand_x, cand_y, N));
    ld_cell      = IW'(idx(in_x, in_y, N));
    legal_c      = in_bound && !vis_q[cand_cell];
    tries_full_c = tries_q[k_idx][3];
    kmin_c       = (len_q == '0) ? '0 : len_q - MW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      kmin_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      prio_q      <= '0;
      vis_q       <= '0;
      fail_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_fail_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      move_q      <= '0;
      for (int unsigned i = 0; i < CELLS; i++) begin
        px_q[i]    <= '0;
        py_q[i]    <= '0;
        tries_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            px_q[0]          <= in_x;
            py_q[0]          <= in_y;
            vis_q[ld_cell]   <= 1'b1;
            len_q            <= move_num;
            prio_q           <= priority_num;
            cnt_q            <= MW'(1);
            state_q          <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt_q < FULL) begin
              px_q[IW'(cnt_q)] <= in_x;
              py_q[IW'(cnt_q)] <= in_y;
              vis_q[ld_cell]   <= 1'b1;
              cnt_q            <= cnt_q + MW'(1);
            end
          end else if (len_q >= FULL) begin
            // Complete prefix: skip the search and emit the first beat now.
            out_valid_q <= 1'b1;
            out_x_q     <= px_q[0];
            out_y_q     <= py_q[0];
            move_q      <= MW'(1);
            fail_q      <= 1'b0;
            cnt_q       <= MW'(1);
            state_q     <= OUT;
          end else begin
            k_q                 <= kmin_c;
            kmin_q              <= kmin_c;
            tries_q[IW'(kmin_c)] <= '0;
            state_q             <= SEARCH;
          end
        end
        SEARCH: begin
          if (tries_full_c) begin
            if (k_q == kmin_q) begin
              out_valid_q <= 1'b1;
              out_fail_q  <= 1'b1;
              fail_q      <= 1'b1;
              state_q     <= OUT;
            end else begin
              vis_q[cur_cell] <= 1'b0;
              k_q             <= k_q - MW'(1);
            end
          end else begin
            tries_q[k_idx] <= tries_q[k_idx] + 4'd1;
            if (legal_c) begin
              px_q[k_nxt_idx]    <= cand_x;
              py_q[k_nxt_idx]    <= cand_y;
              vis_q[cand_cell]   <= 1'b1;
              tries_q[k_nxt_idx] <= '0;
              k_q                <= k_q + MW'(1);
              if (k_q == LAST_M1) begin
                out_valid_q <= 1'b1;
                out_x_q     <= px_q[0];
                out_y_q     <= py_q[0];
                move_q      <= MW'(1);
                fail_q      <= 1'b0;
                cnt_q       <= MW'(1);
                state_q     <= OUT;
              end
            end
          end
        end
        OUT: begin
          if (!fail_q && (cnt_q < FULL)) begin
            out_x_q <= px_q[IW'(cnt_q)];
            out_y_q <= py_q[IW'(cnt_q)];
            move_q  <= cnt_q + MW'(1);
            cnt_q   <= cnt_q + MW'(1);
          end else begin
            out_valid_q <= 1'b0;
            out_fail_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            move_q      <= '0;
            fail_q      <= 1'b0;
            vis_q       <= '0;
            k_q         <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign move_out  = move_q;
  assign out_fail  = out_fail_q;

endmodule

// File: tb/tb_kt_tour_solver.sv
// Self-checking bench for kt_tour_solver (N=5) against a DFS reference model.
module tb_kt_tour_solver;

  localparam int NC     = 25;
  localparam int CAP    = 15000;
  localparam int BUDGET = 60000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_x = '0, in_y = '0, priority_num = '0;
  logic [4:0] move_num = '0;
  logic       out_valid, out_fail;
  logic [2:0] out_x, out_y;
  logic [4:0] move_out;

  kt_tour_solver #(.N(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .move_num(move_num), .priority_num(priority_num), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .move_out(move_out), .out_fail(out_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;       // 0 tour prefix, 1 dead-end prefix, 2 three-cell prefix, 3 single (0,1)
    int len;
    int prio;
    int sym;
    int exp_fail;   // -1: taken from model only
    int exp_steps;  // -1: taken from model only
  } vec_t;

  int checks = 0, errors = 0, spent = 0;
  int dxt [8] = '{-1, 1, 2, 2, 1, -1, -2, -2};
  int dyt [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int tour_r [25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,0,1,3,4,3,1,0,2,4,3,1,2};
  int tour_c [25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,1,3,4,2,0,1,3,4,3,1,0,2};
  int pre_x [25], pre_y [25];
  int plen, pprio;
  int m_x [25], m_y [25];
  bit m_fail, m_abort;
  int m_steps;
  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build_prefix(input int mode, input int len, input int sym);
    int r, c, t;
    plen = len;
    case (mode)
      0: for (int i = 0; i < len; i++) begin
        r = tour_r[i]; c = tour_c[i];
        if ((sym & 1) != 0) begin t = r; r = c; c = t; end
        if ((sym & 2) != 0) r = 4 - r;
        if ((sym & 4) != 0) c = 4 - c;
        pre_x[i] = r; pre_y[i] = c;
      end
      1: begin
        for (int i = 0; i < 22; i++) begin pre_x[i] = tour_r[i]; pre_y[i] = tour_c[i]; end
        pre_x[22] = 1; pre_y[22] = 0; plen = 23;
      end
      2: begin
        pre_x[0] = 0; pre_y[0] = 0; pre_x[1] = 1; pre_y[1] = 2;
        pre_x[2] = 2; pre_y[2] = 4; plen = 3;
      end
      default: begin pre_x[0] = 0; pre_y[0] = 1; plen = 1; end
    endcase
  endtask

  // Depth-first completion following the rules directly: one candidate or backtrack per step.
  task automatic run_model();
    bit vis [5][5];
    int nxt [25];
    int k, kmin, d, nx, ny;
    bit done;
    for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) vis[a][b] = 1'b0;
    for (int i = 0; i < plen; i++) begin
      m_x[i] = pre_x[i]; m_y[i] = pre_y[i]; vis[pre_x[i]][pre_y[i]] = 1'b1;
    end
    m_steps = 0; m_fail = 1'b0; m_abort = 1'b0;
    done = (plen == NC);
    kmin = plen - 1; k = kmin; nxt[k] = 0;
    while (!done) begin
      if (m_steps >= CAP) begin m_abort = 1'b1; done = 1'b1; end
      else begin
        m_steps++;
        if (nxt[k] == 8) begin
          if (k == kmin) begin m_fail = 1'b1; done = 1'b1; end
          else begin vis[m_x[k]][m_y[k]] = 1'b0; k--; end
        end else begin
          d = (pprio + nxt[k]) % 8;
          nxt[k]++;
          nx = m_x[k] + dxt[d]; ny = m_y[k] + dyt[d];
          if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && !vis[nx][ny]) begin
            k++; m_x[k] = nx; m_y[k] = ny; vis[nx][ny] = 1'b1; nxt[k] = 0;
            if (k == NC - 1) done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic drive_prefix();
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_x = 3'(pre_x[i]); in_y = 3'(pre_y[i]);
      move_num = 5'(plen); priority_num = 3'(pprio);
    end
    @(negedge clk);
    in_valid = 1'b0; in_x = '0; in_y = '0;
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "/out_valid"}, int'(out_valid), 0);
    chk({nm, "/payload"}, int'({out_x, out_y, move_out, out_fail}), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) begin @(negedge clk); check_quiet("in_reset"); end
    rst_n = 1'b1;
  endtask

  task automatic run_case(input string name, input int exp_fail, input int exp_steps);
    int cnt, nb, distinct, bad, first_fail, ddx, ddy;
    bit got;
    bit seen [5][5];
    int gx [25], gy [25];
    run_model();
    if (m_abort || spent + m_steps > BUDGET) begin
      $display("note: %s skipped, search longer than this bench allows", name);
      return;
    end
    spent += m_steps + 40;
    drive_prefix();
    cnt = 0; got = 1'b0;
    while (!got && cnt < m_steps + 12) begin
      @(negedge clk); cnt++;
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      chk({name, "/out_valid_timeout"}, int'(out_valid), 1);
      apply_reset();
      return;
    end
    chk({name, "/latency"}, cnt, m_steps + 1);
    if (exp_steps >= 0) chk({name, "/latency_known"}, cnt, exp_steps + 1);
    nb = m_fail ? 1 : NC;
    first_fail = int'(out_fail);
    for (int b = 0; b < nb; b++) begin
      if (b > 0) @(negedge clk);
      chk($sformatf("%s/valid%0d", name, b), int'(out_valid), 1);
      chk($sformatf("%s/fail%0d", name, b), int'(out_fail), int'(m_fail));
      chk($sformatf("%s/move%0d", name, b), int'(move_out), m_fail ? 0 : b + 1);
      chk($sformatf("%s/x%0d", name, b), int'(out_x), m_fail ? 0 : m_x[b]);
      chk($sformatf("%s/y%0d", name, b), int'(out_y), m_fail ? 0 : m_y[b]);
      gx[b] = int'(out_x); gy[b] = int'(out_y);
    end
    if (exp_fail >= 0) chk({name, "/fail_known"}, first_fail, exp_fail);
    @(negedge clk);
    check_quiet({name, "/after"});
    if (!m_fail) begin
      // Independent tour sanity: every cell once, knight steps, prefix head kept.
      for (int a = 0; a < 5; a++) for (int c = 0; c < 5; c++) seen[a][c] = 1'b0;
      distinct = 0; bad = 0;
      for (int b = 0; b < NC; b++) begin
        if (!seen[gx[b]][gy[b]]) distinct++;
        seen[gx[b]][gy[b]] = 1'b1;
        if (b > 0) begin
          ddx = gx[b] - gx[b-1]; ddy = gy[b] - gy[b-1];
          if (ddx * ddx + ddy * ddy != 5) bad++;
        end
      end
      chk({name, "/distinct"}, distinct, NC);
      chk({name, "/knight_steps_bad"}, bad, 0);
      chk({name, "/head_x"}, gx[0], pre_x[0]);
      chk({name, "/head_y"}, gy[0], pre_y[0]);
    end
  endtask

  initial begin
    vecs[0] = '{0, 1, 0, 0, -1, -1};
    vecs[1] = '{3, 1, 3, 0, 1, -1};
    vecs[2] = '{0, 25, 5, 0, 0, 0};
    vecs[3] = '{2, 3, 4, 0, -1, -1};
    vecs[4] = '{1, 23, 0, 0, 1, 27};
    vecs[5] = '{0, 20, 2, 3, -1, -1};
    vecs[6] = '{0, 16, 6, 5, -1, -1};

    @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      build_prefix(vecs[v].mode, vecs[v].len, vecs[v].sym);
      pprio = vecs[v].prio;
      run_case($sformatf("vec%0d", v), vecs[v].exp_fail, vecs[v].exp_steps);
    end

    for (int r = 0; r < 6; r++) begin
      build_prefix(0, int'($urandom_range(14, 24)), int'($urandom_range(0, 7)));
      pprio = int'($urandom_range(0, 7));
      run_case($sformatf("rnd%0d", r), -1, -1);
    end

    // Reset in the middle of a search, then the same job must reproduce exactly.
    build_prefix(0, 10, 0);
    pprio = 1;
    run_model();
    if (!m_abort && m_steps >= 4 && spent + 2 * m_steps < BUDGET) begin
      drive_prefix();
      repeat (2) @(negedge clk);
      check_quiet("pre_abort");
      rst_n = 1'b0;
      repeat (3) begin @(negedge clk); check_quiet("abort_reset"); end
      rst_n = 1'b1;
      run_case("after_abort", -1, -1);
    end else begin
      build_prefix(0, 18, 0);
      pprio = 1;
      drive_prefix();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) begin @(negedge clk); check_quiet("abort_reset"); end
      rst_n = 1'b1;
      run_case("after_abort", -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
